// File: rtl/seg_display_defs.sv
// Shared definitions for the seven-segment scan driver.
//   - scan-state encoding used by the top-level FSM
//   - digit field bounds within the 14-bit captured pattern
//   - all-off drive constants for each pin polarity
//   - small width helpers for parameter-derived counters
package seg_display_defs;

    typedef enum logic [1:0] {
        BLANK0 = 2'd0,
        DIG0   = 2'd1,
        BLANK1 = 2'd2,
        DIG1   = 2'd3
    } scan_state_t;

    localparam int SEG_W    = 7;
    localparam int DISP_W   = 2 * SEG_W;
    localparam int DIG0_LSB = 0;
    localparam int DIG1_LSB = 7;
    localparam int AN_W     = 2;

    // Pin values that leave every segment and anode dark.
    localparam logic [SEG_W-1:0] SEG_OFF_AL = 7'h7F;
    localparam logic [AN_W-1:0]  AN_OFF_AL  = 2'b11;
    localparam logic [SEG_W-1:0] SEG_OFF_AH = 7'h00;
    localparam logic [AN_W-1:0]  AN_OFF_AH  = 2'b00;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_input_filter.sv
// Debounce / capture stage for the 14-bit segment bus.
// A new value must be sampled on STABLE_CYCLES+1 consecutive edges
// (first sighting plus STABLE_CYCLES confirmations) before it is copied
// into disp. update_pulse marks the cycle after disp actually changes.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   seg_in[13:0]    raw segment bus from the processor
//   disp[13:0]      captured, debounced pattern
//   update_pulse    one-cycle pulse after disp changes
module seg_input_filter
    import seg_display_defs::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DISP_W-1:0] seg_in,
    output logic [DISP_W-1:0] disp,
    output logic              update_pulse
);

    localparam int SCNT_W = cnt_w(STABLE_CYCLES);
    localparam logic [SCNT_W-1:0] SCNT_MAX = SCNT_W'(STABLE_CYCLES - 1);

    logic [DISP_W-1:0] cand;
    logic [SCNT_W-1:0] scnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cand         <= '0;
            scnt         <= '0;
            disp         <= '0;
            update_pulse <= 1'b0;
        end else begin
            update_pulse <= 1'b0;
            if (seg_in != cand) begin
                cand <= seg_in;
                scnt <= '0;
            end else if (scnt < SCNT_MAX) begin
                scnt <= scnt + 1'b1;
            end else if (disp != cand) begin
                // scnt saturates here, so it cannot wrap while the input holds
                disp         <= cand;
                update_pulse <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Two-digit seven-segment scan driver.
// Captures the processor's 14-bit segment bus through a debounce filter and
// time-multiplexes both digits onto one shared cathode bus, with a blanking
// gap between digits to avoid ghosting.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   seg_in[13:0]    [13:7] digit1, [6:0] digit0, 1 = segment lit (g..a)
//   enable          1 = scan runs, 0 = display dark
//   seg_out[6:0]    shared segment drive at pin polarity
//   an[1:0]         an[0] digit0, an[1] digit1, at pin polarity
//   frame_tick      one-cycle pulse after each full scan frame
//   update_pulse    one-cycle pulse when the displayed value changes
module seg_scan_driver
    import seg_display_defs::*;
#(
    parameter int CLK_DIV       = 50000,
    parameter int BLANK_CYCLES  = 16,
    parameter int STABLE_CYCLES = 4,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DISP_W-1:0] seg_in,
    input  logic              enable,
    output logic [SEG_W-1:0]  seg_out,
    output logic [AN_W-1:0]   an,
    output logic              frame_tick,
    output logic              update_pulse
);

    localparam int CNT_W = cnt_w(max_int(CLK_DIV, BLANK_CYCLES));
    localparam logic [CNT_W-1:0] DIG_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLANK_CYCLES - 1);

    // XOR masks: logical drive ^ mask gives the pin value, so all-off
    // logical zeros map straight onto the all-off pin constants.
    localparam logic [SEG_W-1:0] SEG_MASK = (ACTIVE_LOW != 0) ? SEG_OFF_AL : SEG_OFF_AH;
    localparam logic [AN_W-1:0]  AN_MASK  = (ACTIVE_LOW != 0) ? AN_OFF_AL  : AN_OFF_AH;

    logic [DISP_W-1:0] disp;

    seg_input_filter #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk          (clk),
        .rst          (rst),
        .seg_in       (seg_in),
        .disp         (disp),
        .update_pulse (update_pulse)
    );

    scan_state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             tick_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= BLANK0;
            cnt        <= '0;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            frame_tick <= tick_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        tick_nxt  = 1'b0;
        if (!enable) begin
            state_nxt = BLANK0;
            cnt_nxt   = '0;
        end else begin
            case (state)
                BLANK0: if (cnt == BLK_LAST) begin
                    state_nxt = DIG0;
                    cnt_nxt   = '0;
                end
                DIG0: if (cnt == DIG_LAST) begin
                    state_nxt = BLANK1;
                    cnt_nxt   = '0;
                end
                BLANK1: if (cnt == BLK_LAST) begin
                    state_nxt = DIG1;
                    cnt_nxt   = '0;
                end
                DIG1: if (cnt == DIG_LAST) begin
                    state_nxt = BLANK0;
                    cnt_nxt   = '0;
                    tick_nxt  = 1'b1;
                end
                default: begin
                    state_nxt = BLANK0;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Decode only from registered state and disp; a disp change shows up
    // on the pins the cycle after it loads without restarting the phase.
    logic [SEG_W-1:0] seg_l;
    logic [AN_W-1:0]  an_l;

    always_comb begin
        seg_l = '0;
        an_l  = '0;
        case (state)
            DIG0: begin
                an_l  = 2'b01;
                seg_l = disp[DIG0_LSB +: SEG_W];
            end
            DIG1: begin
                an_l  = 2'b10;
                seg_l = disp[DIG1_LSB +: SEG_W];
            end
            default: begin
                an_l  = '0;
                seg_l = '0;
            end
        endcase
    end

    assign seg_out = seg_l ^ SEG_MASK;
    assign an      = an_l ^ AN_MASK;

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

    localparam int CD = 4;
    localparam int BL = 1;
    localparam int ST = 3;
    localparam int P  = 2 * (CD + BL);

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [13:0] seg_in;
    logic [6:0]  seg_out;
    logic [1:0]  an;
    logic        frame_tick;
    logic        update_pulse;

    seg_scan_driver #(
        .CLK_DIV       (CD),
        .BLANK_CYCLES  (BL),
        .STABLE_CYCLES (ST),
        .ACTIVE_LOW    (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .seg_in       (seg_in),
        .enable       (enable),
        .seg_out      (seg_out),
        .an           (an),
        .frame_tick   (frame_tick),
        .update_pulse (update_pulse)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: position within the frame plus a sample history.
    int          pos;
    logic [13:0] mdisp;
    logic        m_ft, m_up;
    logic [13:0] hist[$];
    int          up_seen, ft_seen;
    int          cyc, ft_prev, ft_last;

    // 0 = BLANK0, 1 = DIG0, 2 = BLANK1, 3 = DIG1 by frame position
    function automatic int phase_of(input int p);
        if (p < BL)          return 0;
        if (p < BL + CD)     return 1;
        if (p < 2 * BL + CD) return 2;
        return 3;
    endfunction

    function automatic logic [6:0] exp_seg(input int p, input logic [13:0] d);
        case (phase_of(p))
            1:       return ~d[6:0];
            3:       return ~d[13:7];
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [1:0] exp_an(input int p);
        case (phase_of(p))
            1:       return 2'b10;
            3:       return 2'b01;
            default: return 2'b11;
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pos   = 0;
        mdisp = '0;
        m_ft  = 1'b0;
        m_up  = 1'b0;
        hist.delete();
    endtask

    task automatic check_outputs();
        check("seg_out", 16'(seg_out), 16'(exp_seg(pos, mdisp)));
        check("an", 16'(an), 16'(exp_an(pos)));
        check("frame_tick", 16'(frame_tick), 16'(m_ft));
        check("update_pulse", 16'(update_pulse), 16'(m_up));
    endtask

    task automatic step();
        logic eq;
        @(posedge clk);
        if (rst) begin
            m_ft = enable && (pos == P - 1);
            pos  = enable ? (pos + 1) % P : 0;
            hist.push_back(seg_in);
            if (hist.size() > ST + 1) void'(hist.pop_front());
            m_up = 1'b0;
            if (hist.size() == ST + 1) begin
                eq = 1'b1;
                for (int i = 1; i < hist.size(); i++)
                    if (hist[i] != hist[0]) eq = 1'b0;
                if (eq && hist[0] != mdisp) begin
                    mdisp = hist[0];
                    m_up  = 1'b1;
                end
            end
        end
        #1;
        cyc++;
        check_outputs();
        if (update_pulse) up_seen++;
        if (frame_tick) begin
            ft_seen++;
            ft_prev = ft_last;
            ft_last = cyc;
        end
    endtask

    task automatic wait_phase(input int ph);
        int i;
        i = 0;
        while (phase_of(pos) != ph && i < 50) begin
            step();
            i++;
        end
        check("wait_phase", 16'(i < 50), 16'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int u0, f0, i;
        logic [13:0] v;
        up_seen = 0; ft_seen = 0; cyc = 0; ft_prev = 0; ft_last = 0;

        // 1: reset state, then idle scan with seg_in=0
        rst = 1'b0; enable = 1'b0; seg_in = '0;
        model_reset();
        #1;
        check("rst_seg", 16'(seg_out), 16'h007F);
        check("rst_an", 16'(an), 16'h0003);
        check("rst_ft", 16'(frame_tick), 16'd0);
        check("rst_up", 16'(update_pulse), 16'd0);
        repeat (2) step();
        rst = 1'b1;
        enable = 1'b1;
        repeat (30) step();
        check("idle_no_update", 16'(up_seen), 16'd0);
        check("idle_ft_spacing", 16'(ft_last - ft_prev), 16'(P));

        // 2: capture 0A3F and display both digits
        u0 = up_seen;
        seg_in = 14'h0A3F;
        repeat (5) step();
        check("cap_one_update", 16'(up_seen - u0), 16'd1);
        wait_phase(1);
        check("dig0_pattern", 16'(seg_out), 16'h0040);
        wait_phase(3);
        check("dig1_pattern", 16'(seg_out), 16'h006B);

        // 3: short glitch is rejected
        u0 = up_seen;
        seg_in = 14'h3FFF;
        repeat (2) step();
        seg_in = 14'h0A3F;
        repeat (20) step();
        check("glitch_no_update", 16'(up_seen - u0), 16'd0);

        // 4: enable dropped mid-DIG1
        wait_phase(3);
        step();
        enable = 1'b0;
        step();
        check("dis_an", 16'(an), 16'h0003);
        check("dis_seg", 16'(seg_out), 16'h007F);
        f0 = ft_seen;
        repeat (12) step();
        check("dis_no_tick", 16'(ft_seen - f0), 16'd0);
        enable = 1'b1;
        step();
        check("reen_dig0_an", 16'(an), 16'h0002);
        repeat (12) step();

        // 5: reset mid-DIG0
        wait_phase(1);
        step();
        check("pre_rst_dig0", 16'(seg_out), 16'h0040);
        rst = 1'b0;
        seg_in = '0;
        #1;
        model_reset();
        check("async_rst_seg", 16'(seg_out), 16'h007F);
        check("async_rst_an", 16'(an), 16'h0003);
        repeat (2) step();
        rst = 1'b1;
        u0 = up_seen;
        repeat (5) step();
        check("post_rst_no_update", 16'(up_seen - u0), 16'd0);

        // 6: change in last DIG0 cycle
        i = 0;
        while (pos != BL + CD - 1 && i < 50) begin
            step();
            i++;
        end
        check("wait_last_dig0", 16'(i < 50), 16'd1);
        u0 = up_seen;
        seg_in = 14'h007F;
        repeat (3) step();
        check("late_not_yet", 16'(up_seen - u0), 16'd0);
        step();
        check("late_update", 16'(up_seen - u0), 16'd1);
        repeat (25) step();
        check("late_ft_spacing", 16'(ft_last - ft_prev), 16'(P));

        // random segment values, hold lengths and enable drops
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 4))
                0:       v = 14'h0000;
                1:       v = 14'h0A3F;
                2:       v = 14'h3FFF;
                3:       v = 14'h007F;
                default: v = 14'($urandom);
            endcase
            seg_in = v;
            enable = ($urandom_range(0, 7) != 0);
            repeat ($urandom_range(1, 7)) step();
        end
        enable = 1'b1;
        repeat (20) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
